// File: rtl/elevator_request_scheduler.sv
// Single-car LOOK elevator scheduler: latches floor calls, steps the car, holds the door.
// Optional door hold input is enabled by defining ELEVATOR_DOOR_HOLD_EN.
module elevator_request_scheduler #(
    parameter int unsigned NUM_FLOORS    = 5,
    parameter int unsigned TRAVEL_CYCLES = 3,
    parameter int unsigned DOOR_CYCLES   = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_FLOORS-1:0]           call_req,
`ifdef ELEVATOR_DOOR_HOLD_EN
    input  logic                            door_hold,
`endif
    output logic [NUM_FLOORS-1:0]           pending,
    output logic [$clog2(NUM_FLOORS)-1:0]   car_floor,
    output logic                            dir_up,
    output logic                            moving,
    output logic                            door_open
);

    localparam int unsigned FW = $clog2(NUM_FLOORS);
    localparam int unsigned TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int unsigned DW = $clog2(DOOR_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [FW-1:0]          car_floor_n;
    logic                   dir_up_n;
    logic [NUM_FLOORS-1:0]  pending_n;
    logic [TW-1:0]          travel_cnt, travel_cnt_n;
    logic [DW-1:0]          door_cnt, door_cnt_n;

    logic [FW-1:0]          next_floor;
    logic                   ahead, behind, ahead_next;
    logic                   here_req, arrive_req, door_reload;
    logic                   clr_en;
    logic [FW-1:0]          clr_floor;
    logic [NUM_FLOORS-1:0]  clr_mask;

    // True when any call lies strictly beyond floor f in the given direction.
    function automatic logic calls_beyond(input logic [NUM_FLOORS-1:0] pend,
                                          input logic [FW-1:0]         f,
                                          input logic                  up);
        logic found;
        found = 1'b0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (pend[i] && (up ? (i > int'(f)) : (i < int'(f))))
                found = 1'b1;
        end
        return found;
    endfunction

    assign next_floor = dir_up ? car_floor + FW'(1) : car_floor - FW'(1);
    assign ahead      = calls_beyond(pending, car_floor, dir_up);
    assign behind     = calls_beyond(pending, car_floor, ~dir_up);
    assign ahead_next = calls_beyond(pending, next_floor, dir_up);

    // A call arriving on the deciding edge counts as already waiting at that floor.
    assign here_req   = pending[car_floor]  | call_req[car_floor];
    assign arrive_req = pending[next_floor] | call_req[next_floor];

`ifdef ELEVATOR_DOOR_HOLD_EN
    assign door_reload = call_req[car_floor] | door_hold;
`else
    assign door_reload = call_req[car_floor];
`endif

    // Next-state and datapath decisions.
    always_comb begin
        state_n      = state;
        car_floor_n  = car_floor;
        dir_up_n     = dir_up;
        travel_cnt_n = travel_cnt;
        door_cnt_n   = door_cnt;
        clr_en       = 1'b0;
        clr_floor    = car_floor;

        case (state)
            IDLE: begin
                travel_cnt_n = '0;
                door_cnt_n   = '0;
                if (here_req) begin
                    state_n    = DOOR;
                    door_cnt_n = DW'(DOOR_CYCLES);
                    clr_en     = 1'b1;
                end else if (ahead) begin
                    state_n      = MOVE;
                    travel_cnt_n = TW'(TRAVEL_CYCLES);
                end else if (behind) begin
                    state_n      = MOVE;
                    dir_up_n     = ~dir_up;
                    travel_cnt_n = TW'(TRAVEL_CYCLES);
                end
            end

            MOVE: begin
                if (travel_cnt > TW'(1)) begin
                    travel_cnt_n = travel_cnt - TW'(1);
                end else if (!ahead) begin
                    // Nothing left to reach: never step without a target.
                    state_n      = IDLE;
                    travel_cnt_n = '0;
                end else begin
                    car_floor_n = next_floor;
                    if (arrive_req) begin
                        state_n      = DOOR;
                        travel_cnt_n = '0;
                        door_cnt_n   = DW'(DOOR_CYCLES);
                        clr_en       = 1'b1;
                        clr_floor    = next_floor;
                    end else if (ahead_next) begin
                        travel_cnt_n = TW'(TRAVEL_CYCLES);
                    end else begin
                        state_n      = IDLE;
                        travel_cnt_n = '0;
                    end
                end
            end

            DOOR: begin
                clr_en = 1'b1;
                if (door_reload) begin
                    door_cnt_n = DW'(DOOR_CYCLES);
                end else if (door_cnt > DW'(1)) begin
                    door_cnt_n = door_cnt - DW'(1);
                end else begin
                    door_cnt_n = '0;
                    if (ahead) begin
                        state_n      = MOVE;
                        travel_cnt_n = TW'(TRAVEL_CYCLES);
                    end else if (behind) begin
                        state_n      = MOVE;
                        dir_up_n     = ~dir_up;
                        travel_cnt_n = TW'(TRAVEL_CYCLES);
                    end else begin
                        state_n = IDLE;
                    end
                end
            end

            default: begin
                state_n      = IDLE;
                travel_cnt_n = '0;
                door_cnt_n   = '0;
            end
        endcase

        clr_mask  = clr_en ? (NUM_FLOORS'(1) << clr_floor) : '0;
        pending_n = (pending | call_req) & ~clr_mask;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= '0;
            car_floor  <= '0;
            dir_up     <= 1'b1;
            travel_cnt <= '0;
            door_cnt   <= '0;
            moving     <= 1'b0;
            door_open  <= 1'b0;
        end else begin
            state      <= state_n;
            pending    <= pending_n;
            car_floor  <= car_floor_n;
            dir_up     <= dir_up_n;
            travel_cnt <= travel_cnt_n;
            door_cnt   <= door_cnt_n;
            moving     <= (state_n == MOVE);
            door_open  <= (state_n == DOOR);
        end
    end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Scoreboard bench for elevator_request_scheduler: expected door floors are queued with the
// stimulus and popped when the door opens; timing and reset behaviour are checked inline.
module tb_elevator_request_scheduler;

    localparam int unsigned NF = 5;
    localparam int unsigned FW = $clog2(NF);

    logic          clk = 1'b0;
    logic          reset;
    logic [NF-1:0] call_req;
    logic          door_hold;
    logic [NF-1:0] pending;
    logic [FW-1:0] car_floor;
    logic          dir_up;
    logic          moving;
    logic          door_open;

    int n_checks = 0;
    int n_pass   = 0;
    int inv_err  = 0;
    int sb[$];
    logic door_q = 1'b0;

    elevator_request_scheduler #(
        .NUM_FLOORS   (NF),
        .TRAVEL_CYCLES(3),
        .DOOR_CYCLES  (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .call_req (call_req),
`ifdef ELEVATOR_DOOR_HOLD_EN
        .door_hold(door_hold),
`endif
        .pending  (pending),
        .car_floor(car_floor),
        .dir_up   (dir_up),
        .moving   (moving),
        .door_open(door_open)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        else
            n_pass++;
    endtask

    task automatic pulse(input logic [NF-1:0] v);
        call_req = v;
        @(negedge clk);
        call_req = '0;
    endtask

    task automatic do_reset();
        check("sb_drained", 32'(sb.size()), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_floor(input int f, input int budget);
        int n = 0;
        while (int'(car_floor) != f && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_floor", 32'(car_floor), 32'(f));
    endtask

    task automatic wait_door(input int budget);
        int n = 0;
        while (!door_open && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("door_seen", 32'(door_open), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((moving || door_open || pending != '0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("settle", 32'(moving | door_open | (pending != '0)), 32'd0);
    endtask

    task automatic count_door(input string tag, input int exp);
        int n = 0;
        while (door_open && n < 40) begin
            n++;
            @(negedge clk);
        end
        check(tag, 32'(n), 32'(exp));
    endtask

    // Door-opening monitor: pops the expected floor and checks the call was cleared.
    always @(negedge clk) begin
        if (reset) begin
            door_q = 1'b0;
        end else begin
            if (int'(car_floor) >= int'(NF) || (moving && door_open))
                inv_err++;
            if (door_open && !door_q) begin
                if (sb.size() == 0) begin
                    check("door_unexpected", 32'(sb.size()), 32'd1);
                end else begin
                    int exp_floor;
                    exp_floor = sb.pop_front();
                    check("door_floor", 32'(car_floor), 32'(exp_floor));
                    check("door_pend_clr", 32'(pending[car_floor]), 32'd0);
                end
            end
            door_q = door_open;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        call_req  = '0;
        door_hold = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_floor", 32'(car_floor), 32'd0);
        check("rst_dir", 32'(dir_up), 32'd1);
        check("rst_moving", 32'(moving), 32'd0);
        check("rst_door", 32'(door_open), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single call to the top floor: timing of every step and the door window.
        sb.push_back(4);
        pulse(5'b10000);
        check("s1_latch", 32'(pending), 32'b10000);
        check("s1_idle", 32'(moving), 32'd0);
        @(negedge clk);
        check("s1_moving", 32'(moving), 32'd1);
        check("s1_dir", 32'(dir_up), 32'd1);
        check("s1_floor0", 32'(car_floor), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            repeat (3) @(negedge clk);
            check("s1_step", 32'(car_floor), 32'(k));
        end
        check("s1_door", 32'(door_open), 32'd1);
        check("s1_stopped", 32'(moving), 32'd0);
        count_door("s1_door_len", 4);
        check("s1_pend_clr", 32'(pending), 32'd0);
        check("s1_end_idle", 32'(moving), 32'd0);

        // Call latched mid-trip is served on the way.
        do_reset();
        sb.push_back(2);
        sb.push_back(4);
        pulse(5'b10000);
        wait_floor(1, 20);
        pulse(5'b00100);
        wait_door(20);
        check("s2_stop_floor", 32'(car_floor), 32'd2);
        check("s2_pend_left", 32'(pending), 32'b10000);
        check("s2_dir", 32'(dir_up), 32'd1);
        wait_idle(100);
        check("s2_end_floor", 32'(car_floor), 32'd4);

        // LOOK order: keep going up from floor 2, then reverse to floor 0.
        do_reset();
        sb.push_back(2);
        pulse(5'b00100);
        wait_idle(100);
        check("s3_at2", 32'(car_floor), 32'd2);
        check("s3_dir_up", 32'(dir_up), 32'd1);
        sb.push_back(4);
        sb.push_back(0);
        pulse(5'b10001);
        wait_idle(200);
        check("s3_end_floor", 32'(car_floor), 32'd0);
        check("s3_dir_down", 32'(dir_up), 32'd0);

        // Call at the current floor opens the door at once; holding it reloads the timer.
        sb.push_back(0);
        call_req = 5'b00001;
        @(negedge clk);
        check("s4_door_now", 32'(door_open), 32'd1);
        check("s4_floor", 32'(car_floor), 32'd0);
        check("s4_no_pend", 32'(pending), 32'd0);
        repeat (5) @(negedge clk);
        check("s4_reload", 32'(door_open), 32'd1);
        call_req = '0;
        count_door("s4_door_len", 4);
        check("s4_not_latched", 32'(pending), 32'd0);
        check("s4_idle", 32'(moving), 32'd0);

        // Asynchronous reset in the middle of a step between floors 2 and 3.
        do_reset();
        pulse(5'b11000);
        wait_floor(2, 40);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("s5_pending", 32'(pending), 32'd0);
        check("s5_floor", 32'(car_floor), 32'd0);
        check("s5_dir", 32'(dir_up), 32'd1);
        check("s5_moving", 32'(moving), 32'd0);
        check("s5_door", 32'(door_open), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("s5_stays_idle", 32'({moving, door_open}), 32'd0);
        sb.push_back(1);
        pulse(5'b00010);
        wait_idle(100);
        check("s5_resume", 32'(car_floor), 32'd1);

`ifdef ELEVATOR_DOOR_HOLD_EN
        // Door hold keeps the door open until released.
        begin
            int closed = 0;
            sb.push_back(2);
            pulse(5'b00100);
            wait_door(20);
            door_hold = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (!door_open)
                    closed++;
            end
            check("hold_open", 32'(closed), 32'd0);
            door_hold = 1'b0;
            count_door("hold_release_len", 4);
            wait_idle(100);
        end
`endif

        repeat (3) @(negedge clk);
        check("sb_final", 32'(sb.size()), 32'd0);
        check("invariants", 32'(inv_err), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/elevator_request_scheduler.md
ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 5, number of floors (2..16).
REQ-002 SHALL have parameter TRAVEL_CYCLES, default 3, clock cycles per one-floor step (>=1).
REQ-003 SHALL have parameter DOOR_CYCLES, default 4, clock cycles the door stays open (>=1).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port call_req, input, NUM_FLOORS, per-floor call buttons, level or pulse, bit i = floor i.
REQ-007 SHALL have port pending, output, NUM_FLOORS, latched outstanding calls.
REQ-008 SHALL have port car_floor, output, $clog2(NUM_FLOORS), current car floor index.
REQ-009 SHALL have port dir_up, output, 1, travel direction, 1 = up.
REQ-010 SHALL have ports moving and door_open, output, 1 each, asserted in MOVE and DOOR states respectively.

Function
REQ-011 SHALL implement FSM states IDLE, MOVE, DOOR; moving=(state==MOVE), door_open=(state==DOOR), both registered.
REQ-012 SHALL set pending[i] on the edge where call_req[i]=1; bits stay set until served; one-cycle latch latency.
REQ-013 SHALL define "ahead" as any pending bit strictly beyond car_floor in dir_up's direction; "behind" as any strictly on the opposite side.
REQ-014 IDLE: if pending[car_floor] then DOOR next edge; else if ahead then MOVE same dir; else if behind then MOVE with dir_up toggled; else stay IDLE.
REQ-015 MOVE: a travel counter counts TRAVEL_CYCLES cycles; on the final cycle car_floor steps +1 (dir_up=1) or -1; counter reloads for each step.
REQ-016 On arrival at a floor whose pending bit is set (including calls latched mid-step), SHALL go to DOOR on that arrival edge; otherwise continue MOVE.
REQ-017 On DOOR entry SHALL clear pending[car_floor] on the same edge; a call_req for car_floor on that edge SHALL NOT be latched.
REQ-018 DOOR: door counter runs DOOR_CYCLES cycles; call_req[car_floor]=1 during DOOR SHALL reload the counter and SHALL NOT be latched.
REQ-019 At DOOR expiry SHALL apply the REQ-014 decision (excluding the car_floor check) and go to MOVE or IDLE on the next edge.
REQ-020 car_floor SHALL never leave 0..NUM_FLOORS-1; a step SHALL only occur when a pending bit exists ahead.
REQ-021 Call bits at or beyond NUM_FLOORS do not exist; simultaneous calls on multiple floors SHALL all be latched in the same cycle.
REQ-022 With both ahead and behind calls, SHALL keep the current direction (LOOK order).

Reset
REQ-023 reset=1 SHALL asynchronously force state=IDLE, pending=0, car_floor=0, dir_up=1, moving=0, door_open=0, counters=0.
REQ-024 Reset mid-MOVE or mid-DOOR SHALL discard all calls and the partial step; after release, operation resumes from floor 0 in IDLE.

Configuration
REQ-025 With macro ELEVATOR_DOOR_HOLD_EN defined, SHALL add input door_hold (1 bit); door_hold=1 in DOOR SHALL hold the counter at DOOR_CYCLES, keeping the door open until released.
REQ-026 Without ELEVATOR_DOOR_HOLD_EN, port door_hold SHALL be absent and DOOR always expires per REQ-018.

Verification (NUM_FLOORS=5, TRAVEL_CYCLES=3, DOOR_CYCLES=4)
REQ-027 Reset, call_req=5'b10000 one cycle -> pending=5'b10000, MOVE up, car_floor 1,2,3,4 every 3 cycles, door_open 4 cycles at floor 4, pending=0, IDLE.
REQ-028 Car moving 0->4, call_req=5'b00100 pulsed while at floor 1 -> door opens at floor 2 first, then continues to 4.
REQ-029 Car idle at 2 with dir_up=1, call_req=5'b10001 same cycle -> serves floor 4 first, then dir_up=0, serves floor 0.
REQ-030 Idle at floor 0, call_req=5'b00001 -> door_open next edge, car_floor stays 0, pending bit never persists.
REQ-031 reset asserted mid-step between floors 2 and 3 -> outputs immediately at reset values, pending=0.
REQ-032 With ELEVATOR_DOOR_HOLD_EN, door_hold=1 for 10 cycles in DOOR -> door_open stays 1 throughout, closes 4 cycles after release.
